arb_mux_rr: RTL and testbench
=============================

# arb_mux_rr

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and a registered output stage. It generalises the one-hot select mux used on NPC datapaths: the select is produced internally by a round-robin arbiter over requesting channels instead of being driven externally. The block sits wherever several producers share one consumer, such as IFU/LSU requests into a shared memory port or multiple write-back sources. The winning beat is held in an output register until the consumer accepts it.

## Interface
- `WIDTH`, 32, payload width per channel.
- `N`, 5, channel count; legal range 1..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  N  per-channel request; bit i belongs to channel i.
- `in_ready`  out  N  per-channel accept; at most one bit is high in any cycle.
- `in_data`  in  N*WIDTH  channel i payload is in bits [i*WIDTH +: WIDTH].
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  WIDTH  registered payload.
- `out_grant`  out  N  one-hot, registered; identifies the source channel of `out_data`.

## Operation
- `ptr`: priority pointer, width clog2(N) (minimum 1). Channel `ptr` has highest priority; priority then falls in order ptr+1, …, N-1, 0, …, ptr-1.
- `grant`: combinational one-hot. It selects the first requesting channel in priority order. It is all-zero when `in_valid` == 0.
- `load = ~out_valid | out_ready`. The output register can accept a beat this cycle.
- `in_ready[i] = grant[i] & load`. This is combinational from `in_valid`, `out_ready` and state. It never depends on `in_data`.
- Transfer on channel i occurs when `in_valid[i] & in_ready[i]`. At that edge:
  - `out_data` <= channel i payload.
  - `out_grant` <= `grant`.
  - `out_valid` <= 1.
  - `ptr` <= (i+1) mod N.
- Output accepted and no new transfer: `out_valid` <= 0. `out_data` and `out_grant` hold their values.
- `out_valid & ~out_ready`: `out_data`, `out_grant` and `ptr` are all frozen. All `in_ready` bits are 0.
- Payload selection is an AND-OR over the one-hot `grant`. It needs no binary decoder.
- Input-side rules:
  - A channel may deassert `in_valid` before it is accepted; the arbiter simply re-evaluates.
  - Losing channels are never dropped. They stay pending as long as their `in_valid` is held.
- `N`=1: `ptr` is constant 0 and `grant = in_valid`. The block degenerates to a one-stage pipeline register.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_grant`=0, `ptr`=0.
  - `in_ready`=0 while `rst` is high.
- Latency: an input accepted at edge k appears on `out_*` in the cycle after edge k (1 cycle).
- Throughput: 1 beat/cycle when `out_ready` is held high. Back-to-back transfers occur with no bubble.
- Simultaneous accept-and-load (`out_valid & out_ready` plus an input transfer at the same edge): the new beat replaces the old one and `out_valid` stays 1.
- Pointer wrap-around: a grant to channel N-1 sets `ptr` to 0.
- Fairness: with all N channels continuously requesting, each channel is granted exactly once in any N consecutive transfers.
- Reset mid-operation: any beat held in the output register is discarded, and `ptr` returns to 0 at that edge.

## Configuration
- `ARB_MUX_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest requesting index always wins, `ptr` is removed, and starvation of high indices is permitted.
  - Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset then idle: assert `rst` for 2 cycles with all `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0, `out_grant`=0. On the first cycle after reset, `in_ready`=5'b00001.
- Round-robin sweep (N=5, `out_ready`=1, all channels valid, `in_data[i]`=0x100+i) → `out_data` sequence 0x100, 0x101, 0x102, 0x103, 0x104, 0x100 on consecutive cycles. `out_grant` walks 00001 → 10000 → 00001, showing the wrap.
- Backpressure: only channel 2 valid with 0xDEAD_BEEF, `out_ready`=0 for 4 cycles → `out_valid`=1 and `out_data`=0xDEAD_BEEF stay stable, with `in_ready`=0 throughout. Raising `out_ready` for one cycle gives `out_valid`=0 on the next cycle.
- Simultaneous accept and load: `out_valid`=1 (channel 0), `out_ready`=1, channel 3 valid with 0x33 → next cycle `out_valid`=1, `out_data`=0x33, `out_grant`=01000.
- Sparse requests: channels 1 and 4 valid, `ptr`=2 → channel 4 is granted first, then channel 1. Channels 0, 2 and 3 never show `in_ready`=1.
- Reset mid-stream: assert `rst` while `out_valid`=1 and `ptr`=3 → next cycle `out_valid`=0. The following grant with all channels valid goes to channel 0. With `ARB_MUX_FIXED_PRIO_EN` defined, the sweep scenario yields channel 0 on every cycle.

Source files
------------

// File: rtl/arb_mux_rr.sv
// rtl/arb_mux_rr.sv - N-channel round-robin arbitrating mux with registered output
//
// Purpose: several valid/ready producers share one consumer. An internal
// arbiter picks one requesting channel per cycle. The winning payload is
// captured in an output register, which holds it until the consumer accepts it.
//
// Build option: define ARB_MUX_FIXED_PRIO_EN to get fixed priority, where the
// lowest requesting index always wins and there is no rotating pointer.
// Left undefined (the default), the arbiter is round-robin.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   [N]        per-channel request
//   in_ready   [N]        per-channel accept (at most one bit high)
//   in_data    [N*WIDTH]  channel i payload at [i*WIDTH +: WIDTH]
//   out_valid             output register holds a beat
//   out_ready             consumer accepts the beat
//   out_data   [WIDTH]    registered payload
//   out_grant  [N]        registered one-hot source channel of out_data

module arb_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [N-1:0]       out_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Isolate the lowest set bit.
  function automatic logic [N-1:0] lowest(input logic [N-1:0] x);
    return x & (~x + N'(1));
  endfunction

  logic [N-1:0]     grant;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

`ifdef ARB_MUX_FIXED_PRIO_EN

  assign grant = lowest(in_valid);

`else

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] grant_idx;
  logic [N-1:0]  mask_hi;
  logic [N-1:0]  req_hi;

  // Two-pass round robin: first look only at channels at or above ptr. If
  // none of those request, the search wraps and takes the lowest requester
  // overall.
  assign mask_hi = ~((N'(1) << ptr) - N'(1));
  assign req_hi  = in_valid & mask_hi;
  assign grant   = (|req_hi) ? lowest(req_hi) : lowest(in_valid);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // The pointer moves one past the winner and wraps after channel N-1. For
  // N=1 this stays at 0.
  assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

`endif

  assign load     = ~out_valid | out_ready;
  assign in_ready = rst ? '0 : (grant & {N{load}});
  // grant is a subset of in_valid, so any ready bit means a transfer.
  assign xfer     = |in_ready;

  // AND-OR payload select over the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
`ifndef ARB_MUX_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_grant <= grant;
`ifndef ARB_MUX_FIXED_PRIO_EN
      ptr       <= ptr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb/tb_arb_mux_rr.sv - self-checking bench for arb_mux_rr (default round-robin build)

module tb_arb_mux_rr;

  localparam int W = 32;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_grant;

  int errors = 0;
  int checks = 0;

  arb_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_grant (out_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic [N-1:0]  v;
    logic          ordy;
    logic [W-1:0]  base;
    logic [N-1:0]  e_rdy;
    logic          e_ov;
    logic [W-1:0]  e_od;
    logic [N-1:0]  e_og;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [N-1:0] v, logic o, logic [W-1:0] b,
                              logic [N-1:0] er, logic ev, logic [W-1:0] ed,
                              logic [N-1:0] eg);
    vec_t t;
    t.r = r; t.v = v; t.ordy = o; t.base = b;
    t.e_rdy = er; t.e_ov = ev; t.e_od = ed; t.e_og = eg;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic drive_data(logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  int            cnt[N];
  int            exp_ptr;
  int            xfers;
  int            cyc;
  logic [N-1:0]  e_r;

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;

    // reset with all channels requesting
    vecs.push_back(mk(1, 5'b11111, 1, 32'h100, 5'b00000, 0, 32'h0,   5'b00000));
    vecs.push_back(mk(1, 5'b11111, 1, 32'h100, 5'b00000, 0, 32'h0,   5'b00000));
    // round-robin sweep with wrap
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b00001, 1, 32'h100, 5'b00001));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b00010, 1, 32'h101, 5'b00010));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b00100, 1, 32'h102, 5'b00100));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b01000, 1, 32'h103, 5'b01000));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b10000, 1, 32'h104, 5'b10000));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b00001, 1, 32'h100, 5'b00001));
    // simultaneous accept and load: ch0 held, ch3 replaces it
    vecs.push_back(mk(0, 5'b01000, 1, 32'h30,  5'b01000, 1, 32'h33,  5'b01000));
    // backpressure on channel 2
    vecs.push_back(mk(0, 5'b00100, 1, 32'hDEADBEED, 5'b00100, 1, 32'hDEADBEEF, 5'b00100));
    vecs.push_back(mk(0, 5'b00100, 0, 32'hDEADBEED, 5'b00000, 1, 32'hDEADBEEF, 5'b00100));
    vecs.push_back(mk(0, 5'b00100, 0, 32'hDEADBEED, 5'b00000, 1, 32'hDEADBEEF, 5'b00100));
    vecs.push_back(mk(0, 5'b00100, 0, 32'hDEADBEED, 5'b00000, 1, 32'hDEADBEEF, 5'b00100));
    vecs.push_back(mk(0, 5'b00100, 0, 32'hDEADBEED, 5'b00000, 1, 32'hDEADBEEF, 5'b00100));
    vecs.push_back(mk(0, 5'b00000, 1, 32'hDEADBEED, 5'b00000, 0, 32'hDEADBEEF, 5'b00100));
    // grant ch1 so ptr=2, then sparse requests on channels 1 and 4
    vecs.push_back(mk(0, 5'b00010, 1, 32'h200, 5'b00010, 1, 32'h201, 5'b00010));
    vecs.push_back(mk(0, 5'b10010, 1, 32'h200, 5'b10000, 1, 32'h204, 5'b10000));
    vecs.push_back(mk(0, 5'b10010, 1, 32'h200, 5'b00010, 1, 32'h201, 5'b00010));
    vecs.push_back(mk(0, 5'b10010, 1, 32'h200, 5'b10000, 1, 32'h204, 5'b10000));
    // grant ch2 so ptr=3 with a held beat, then reset mid-stream
    vecs.push_back(mk(0, 5'b00100, 1, 32'h200, 5'b00100, 1, 32'h202, 5'b00100));
    vecs.push_back(mk(1, 5'b11111, 0, 32'h200, 5'b00000, 0, 32'h0,   5'b00000));
    vecs.push_back(mk(0, 5'b11111, 1, 32'h100, 5'b00001, 1, 32'h100, 5'b00001));

    @(posedge clk); #1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].r; in_valid = vecs[k].v; out_ready = vecs[k].ordy;
      drive_data(vecs[k].base);
      #3;
      chk("in_ready", k, W'(in_ready), W'(vecs[k].e_rdy));
      @(posedge clk); #1;
      chk("out_valid", k, W'(out_valid), W'(vecs[k].e_ov));
      chk("out_data",  k, out_data,      vecs[k].e_od);
      chk("out_grant", k, W'(out_grant), W'(vecs[k].e_og));
    end

    // Fairness under random backpressure: ptr is 1 and a beat is held.
    for (int i = 0; i < N; i++) cnt[i] = 0;
    exp_ptr = 1; xfers = 0; cyc = 0;
    in_valid = '1; drive_data(32'h100);
    while (xfers < 2*N && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      #3;
      e_r = (!out_valid || out_ready) ? (N'(1) << exp_ptr) : '0;
      chk("fair_ready", cyc, W'(in_ready), W'(e_r));
      @(posedge clk); #1;
      if (e_r != '0) begin
        chk("fair_data", cyc, out_data, 32'h100 + W'(exp_ptr));
        cnt[exp_ptr]++;
        exp_ptr = (exp_ptr + 1) % N;
        xfers++;
      end
      cyc++;
    end
    checks++;
    if (xfers < 2*N) begin
      errors++;
      $display("FAIL fair_budget: got %0d transfers want %0d", xfers, 2*N);
    end
    for (int i = 0; i < N; i++) chk("fair_count", i, W'(cnt[i]), W'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
